cic_iq_sched: RTL
=================

CIC_IQ_SCHED -- requirements
Module: cic_iq_sched

Interface
REQ-001 SHALL have parameter DIN_W, default 16, input and output sample width.
REQ-002 SHALL have parameter CORE_W, default 23, shared decimator result width.
REQ-003 SHALL have parameter GAIN_SHIFT, default 7, result right-shift (0..CORE_W-1).
REQ-004 SHALL have port clk  in  1  single clock; all flops rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports real_tdata/imag_tdata  in  DIN_W  I/Q samples, two's complement.
REQ-007 SHALL have ports real_tvalid/imag_tvalid  in  1, and real_tready/imag_tready  out  1.
REQ-008 SHALL have ports core_tdata  out  DIN_W, core_tuser  out  1 (0=I, 1=Q), core_tvalid  out  1, core_tready  in  1.
REQ-009 SHALL have ports res_tdata  in  CORE_W, res_tuser  in  1, res_tvalid  in  1, from the shared decimator.
REQ-010 SHALL have ports real_fc/imag_fc  out  DIN_W, fc_valid  out  1, pair_cnt  out  16, seq_err  out  1, err_clr  in  1.

Function
REQ-011 Issue FSM states SHALL be S_IDLE, S_SEND_I and S_SEND_Q.
REQ-012 real_tready and imag_tready SHALL both equal (state==S_IDLE) & real_tvalid & imag_tvalid, so a pair is accepted atomically.
REQ-013 On pair acceptance, both samples SHALL be latched into hold registers, and the FSM SHALL go to S_SEND_I.
REQ-014 In S_SEND_I the block SHALL drive core_tvalid=1, core_tdata=I hold and core_tuser=0; on core_tready it SHALL go to S_SEND_Q.
REQ-015 In S_SEND_Q the block SHALL drive core_tvalid=1, core_tdata=Q hold and core_tuser=1; on core_tready it SHALL go to S_IDLE.
REQ-016 Once asserted, core_tvalid, core_tdata and core_tuser SHALL stay stable until core_tready is sampled high.
REQ-017 Minimum issue cadence SHALL be 3 cycles per pair: accept, then I, then Q.
REQ-018 Result collector states SHALL be C_EXP_I and C_EXP_Q.
REQ-019 In C_EXP_I, res_tvalid with res_tuser=0 SHALL latch the converted I result and move the collector to C_EXP_Q.
REQ-020 In C_EXP_Q, res_tvalid with res_tuser=1 SHALL register real_fc/imag_fc and pulse fc_valid for 1 cycle on the next edge; the collector SHALL return to C_EXP_I.
REQ-021 Any res_tuser out of sequence SHALL set seq_err (sticky), discard the sample, and put the collector in C_EXP_I.
REQ-022 err_clr SHALL clear seq_err; if a new error and err_clr occur in the same cycle, the error SHALL win.
REQ-023 pair_cnt SHALL increment on each fc_valid, wrapping 0xFFFF->0x0000.
REQ-024 Conversion SHALL compute r = (res_tdata + 2^(GAIN_SHIFT-1)) >>> GAIN_SHIFT, arithmetic, in CORE_W+1 bits; for GAIN_SHIFT=0 it SHALL apply no rounding.
REQ-025 real_fc and imag_fc SHALL hold their values between fc_valid pulses.
REQ-026 The issue FSM and the collector SHALL run independently; an issue and a result in the same cycle SHALL both be honoured.

Reset
REQ-027 rst_n low SHALL asynchronously force: state S_IDLE, collector C_EXP_I, all *_tready=0, core_tvalid=0, core_tdata=0, core_tuser=0, real_fc=imag_fc=0, fc_valid=0, pair_cnt=0, seq_err=0.
REQ-028 Reset mid-transfer SHALL drop any held pair or half-collected pair with no partial output.
REQ-029 Reset release SHALL be synchronised internally, with 2 flops, before the FSMs leave reset.

Configuration
REQ-030 With CIC_IQ_SAT_EN defined, r SHALL saturate to [-2^(DIN_W-1), 2^(DIN_W-1)-1].
REQ-031 Without CIC_IQ_SAT_EN, the output SHALL be the low DIN_W bits of r (wrap).

Structure
REQ-032 A shared package cic_iq_pkg SHALL hold the issue/collector state enums, the channel-id constants CH_I=0 and CH_Q=1, and the width defaults.
REQ-033 Conversion (round, shift, sat/wrap) SHALL be a sub-module cic_iq_round, instanced once and shared by the I and Q paths.

Verification
REQ-034 Test: both valid, I=0x1234, Q=0xFEDC, core_tready=1 -> core_tdata 0x1234 (tuser 0) then 0xFEDC (tuser 1) on consecutive cycles, then back to S_IDLE.
REQ-035 Test: only real_tvalid=1 for 10 cycles -> both tready stay 0; core_tvalid stays 0.
REQ-036 Test: core_tready held low 5 cycles in S_SEND_I -> core_tdata/core_tuser stable; I issued on cycle 6.
REQ-037 Test: results 23'h000080 (tuser 0) then 23'h7FFF80 (tuser 1), GAIN_SHIFT=7 -> real_fc=0x0001, imag_fc=0xFFFF, 1-cycle fc_valid, pair_cnt=1.
REQ-038 Test: result 23'h3FFFFF, GAIN_SHIFT=7 -> 0x7FFF with CIC_IQ_SAT_EN, 0x8000 without.
REQ-039 Test: two tuser=1 results in a row -> seq_err=1, no fc_valid; err_clr pulse -> seq_err=0; rst_n low mid-S_SEND_Q -> all outputs at reset values.

Source files
------------

// File: rtl/cic_iq_pkg.sv
// rtl/cic_iq_pkg.sv - shared types and defaults for the CIC I/Q scheduler
package cic_iq_pkg;

    localparam int DIN_W_DEF      = 16;
    localparam int CORE_W_DEF     = 23;
    localparam int GAIN_SHIFT_DEF = 7;

    localparam logic CH_I = 1'b0;
    localparam logic CH_Q = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_I,
        S_SEND_Q
    } issue_state_t;

    typedef enum logic {
        C_EXP_I,
        C_EXP_Q
    } coll_state_t;

endpackage

// File: rtl/cic_iq_round.sv
// rtl/cic_iq_round.sv - round, arithmetic shift and saturate/wrap; CIC_IQ_SAT_EN selects saturation
module cic_iq_round #(
    parameter int DIN_W      = 16,
    parameter int CORE_W     = 23,
    parameter int GAIN_SHIFT = 7
) (
    input  logic [CORE_W-1:0] din,
    output logic [DIN_W-1:0]  dout
);

    // One guard bit so the rounding add cannot overflow.
    logic signed [CORE_W:0] ext;
    logic signed [CORE_W:0] r;

    assign ext = {din[CORE_W-1], din};

    generate
        if (GAIN_SHIFT == 0) begin : g_noround
            assign r = ext;
        end else begin : g_round
            localparam logic signed [CORE_W:0] RND = (CORE_W+1)'(1) << (GAIN_SHIFT - 1);
            assign r = (ext + RND) >>> GAIN_SHIFT;
        end
    endgenerate

`ifdef CIC_IQ_SAT_EN
    localparam logic signed [CORE_W:0] SAT_MAX = (CORE_W+1)'((1 << (DIN_W - 1)) - 1);
    localparam logic signed [CORE_W:0] SAT_MIN = -SAT_MAX - 1;

    assign dout = (r > SAT_MAX) ? SAT_MAX[DIN_W-1:0] :
                  (r < SAT_MIN) ? SAT_MIN[DIN_W-1:0] : r[DIN_W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^r[CORE_W:DIN_W];
    assign dout      = r[DIN_W-1:0];
`endif

endmodule

// File: rtl/cic_iq_sched.sv
// rtl/cic_iq_sched.sv - I/Q pair issue to a shared decimator and result re-pairing; CIC_IQ_SAT_EN enables output saturation
module cic_iq_sched
    import cic_iq_pkg::*;
#(
    parameter int DIN_W      = DIN_W_DEF,
    parameter int CORE_W     = CORE_W_DEF,
    parameter int GAIN_SHIFT = GAIN_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  real_tdata,
    input  logic              real_tvalid,
    output logic              real_tready,
    input  logic [DIN_W-1:0]  imag_tdata,
    input  logic              imag_tvalid,
    output logic              imag_tready,
    output logic [DIN_W-1:0]  core_tdata,
    output logic              core_tuser,
    output logic              core_tvalid,
    input  logic              core_tready,
    input  logic [CORE_W-1:0] res_tdata,
    input  logic              res_tuser,
    input  logic              res_tvalid,
    output logic [DIN_W-1:0]  real_fc,
    output logic [DIN_W-1:0]  imag_fc,
    output logic              fc_valid,
    output logic [15:0]       pair_cnt,
    output logic              seq_err,
    input  logic              err_clr
);

    // Assertion follows rst_n immediately; release is delayed two clocks.
    logic [1:0] rst_sync;
    logic       rst_i_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_i_n = rst_sync[1];

    issue_state_t     state, state_nxt;
    logic             accept;
    logic [DIN_W-1:0] i_hold, q_hold;

    always_comb begin
        accept      = (state == S_IDLE) & real_tvalid & imag_tvalid & rst_i_n;
        state_nxt   = state;
        core_tvalid = 1'b0;
        core_tdata  = '0;
        core_tuser  = CH_I;
        case (state)
            S_IDLE: if (accept) state_nxt = S_SEND_I;
            S_SEND_I: begin
                core_tvalid = 1'b1;
                core_tdata  = i_hold;
                core_tuser  = CH_I;
                if (core_tready) state_nxt = S_SEND_Q;
            end
            S_SEND_Q: begin
                core_tvalid = 1'b1;
                core_tdata  = q_hold;
                core_tuser  = CH_Q;
                if (core_tready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign real_tready = accept;
    assign imag_tready = accept;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state  <= S_IDLE;
            i_hold <= '0;
            q_hold <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                i_hold <= real_tdata;
                q_hold <= imag_tdata;
            end
        end
    end

    coll_state_t      coll, coll_nxt;
    logic [DIN_W-1:0] res_conv, i_res;
    logic             take_i, take_q, res_bad;

    cic_iq_round #(
        .DIN_W      (DIN_W),
        .CORE_W     (CORE_W),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_round (
        .din  (res_tdata),
        .dout (res_conv)
    );

    always_comb begin
        coll_nxt = coll;
        take_i   = 1'b0;
        take_q   = 1'b0;
        res_bad  = 1'b0;
        if (res_tvalid) begin
            if (coll == C_EXP_I && res_tuser == CH_I) begin
                take_i   = 1'b1;
                coll_nxt = C_EXP_Q;
            end else if (coll == C_EXP_Q && res_tuser == CH_Q) begin
                take_q   = 1'b1;
                coll_nxt = C_EXP_I;
            end else begin
                res_bad  = 1'b1;
                coll_nxt = C_EXP_I;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            coll     <= C_EXP_I;
            i_res    <= '0;
            real_fc  <= '0;
            imag_fc  <= '0;
            fc_valid <= 1'b0;
            pair_cnt <= '0;
            seq_err  <= 1'b0;
        end else begin
            coll     <= coll_nxt;
            fc_valid <= take_q;
            if (take_i) i_res <= res_conv;
            if (take_q) begin
                real_fc  <= i_res;
                imag_fc  <= res_conv;
                pair_cnt <= pair_cnt + 16'd1;
            end
            // A fresh error outranks a simultaneous clear.
            if (res_bad)      seq_err <= 1'b1;
            else if (err_clr) seq_err <= 1'b0;
        end
    end

endmodule
